mac_frame_builder: RTL

- Upstream feeder of the GbE MAC transmitter.
- Waits until the acquisition byte FIFO (FWFT) holds a full payload, then pulses the transmitter trigger.
- Serves the byte stream on each transmitter strobe: preamble + SFD, destination MAC, source MAC, EtherType, optional sequence header, then PAYLOAD_LEN FIFO bytes.
- Flags the final byte with Last_byte_o. The transmitter itself appends the FCS.

---
 rtl/mac_frame_pkg.sv | 22 ++
 rtl/mac_hdr_sel.sv | 40 ++++
 rtl/mac_frame_builder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mac_frame_pkg.sv
// mac_frame_pkg: state encoding and frame layout constants shared by the
// mac_frame_builder block and its header byte selector.
package mac_frame_pkg;

   // Frame builder sequencing states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_TRIG = 3'd1,
      ST_PRE  = 3'd2,
      ST_HDR  = 3'd3,
      ST_PAY  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;

   localparam int PRE_LEN     = 8;   // 7 preamble bytes + SFD
   localparam int MAC_HDR_LEN = 14;  // dst(6) + src(6) + EtherType(2)
   localparam int SEQ_HDR_LEN = 4;   // frame counter(2) + payload length(2)

endpackage

// File: rtl/mac_hdr_sel.sv
// mac_hdr_sel: combinational selector returning one Ethernet header byte
// for a given header index. Indices 0..13 cover dst/src MAC and EtherType,
// 14..17 the optional sequence header; anything else returns 0.
module mac_hdr_sel (
   input  logic [4:0]  i_idx,
   input  logic [47:0] i_dst_mac,
   input  logic [47:0] i_src_mac,
   input  logic [15:0] i_ethertype,
   input  logic [15:0] i_seq_cnt,
   input  logic [15:0] i_seq_len,
   output logic [7:0]  o_byte
);

   // Byte mux: every multi-byte field goes out most significant byte first
   always_comb begin
      o_byte = 8'h00;
      case (i_idx)
         5'd0:    o_byte = i_dst_mac[47:40];
         5'd1:    o_byte = i_dst_mac[39:32];
         5'd2:    o_byte = i_dst_mac[31:24];
         5'd3:    o_byte = i_dst_mac[23:16];
         5'd4:    o_byte = i_dst_mac[15:8];
         5'd5:    o_byte = i_dst_mac[7:0];
         5'd6:    o_byte = i_src_mac[47:40];
         5'd7:    o_byte = i_src_mac[39:32];
         5'd8:    o_byte = i_src_mac[31:24];
         5'd9:    o_byte = i_src_mac[23:16];
         5'd10:   o_byte = i_src_mac[15:8];
         5'd11:   o_byte = i_src_mac[7:0];
         5'd12:   o_byte = i_ethertype[15:8];
         5'd13:   o_byte = i_ethertype[7:0];
         5'd14:   o_byte = i_seq_cnt[15:8];
         5'd15:   o_byte = i_seq_cnt[7:0];
         5'd16:   o_byte = i_seq_len[15:8];
         5'd17:   o_byte = i_seq_len[7:0];
         default: o_byte = 8'h00;
      endcase
   end

endmodule

// File: rtl/mac_frame_builder.sv
// mac_frame_builder: feeds the GbE MAC transmitter. Waits for a full payload
// in the FWFT byte FIFO, pulses Trig_o, then serves preamble/SFD, Ethernet
// header and payload one byte per transmitter strobe. The FCS is added by
// the transmitter.
// Build option: define FRAME_SEQ_EN to insert a 4-byte sequence header
// (frame counter, payload length) after the EtherType.
module mac_frame_builder
   import mac_frame_pkg::*;
#(
   parameter int          PAYLOAD_LEN  = 1024,
   parameter logic [15:0] ETHERTYPE    = 16'h88B5,
   parameter int          TRIG_TIMEOUT = 63
) (
   input  logic        clk,
   input  logic        Reset_i,
   input  logic        Enable_i,
   input  logic [47:0] Dst_mac_i,
   input  logic [47:0] Src_mac_i,
   input  logic [7:0]  Src_data_i,
   input  logic        Src_empty_i,
   input  logic [13:0] Src_count_i,
   output logic        Src_rd_o,
   input  logic        Mac_busy_i,
   input  logic        Data_strobe_i,
   output logic        Trig_o,
   output logic [7:0]  Data_o,
   output logic        Last_byte_o,
   output logic [15:0] Frame_cnt_o,
   output logic        Underflow_o
);

`ifdef FRAME_SEQ_EN
   localparam int HDR_LEN = MAC_HDR_LEN + SEQ_HDR_LEN;
`else
   localparam int HDR_LEN = MAC_HDR_LEN;
`endif

   localparam logic [13:0] LP_PAY_LEN  = 14'(PAYLOAD_LEN);
   localparam logic [13:0] LP_PAY_LAST = 14'(PAYLOAD_LEN - 1);
   localparam logic [13:0] LP_PRE_LAST = 14'(PRE_LEN - 1);
   localparam logic [13:0] LP_HDR_LAST = 14'(HDR_LEN - 1);
   localparam logic [15:0] LP_SEQ_LEN  = 16'(PAYLOAD_LEN);
   localparam logic [15:0] LP_TMO_LAST = 16'(TRIG_TIMEOUT - 1);

   state_t      r_state;
   logic [13:0] r_cnt;        // index of the byte currently on Data_o within its section
   logic [15:0] r_tmo;
   logic [47:0] r_dst_mac;
   logic [47:0] r_src_mac;
   logic [7:0]  r_data;
   logic        r_trig;
   logic        r_last;
   logic        r_underflow;
   logic [15:0] r_frame_cnt;

   logic [13:0] w_cnt_inc;
   logic [4:0]  w_hdr_idx;
   logic [7:0]  w_hdr_byte;
   logic [7:0]  w_pay_byte;
   logic        w_start;
   logic        w_pay_load;

   assign w_cnt_inc = r_cnt + 14'd1;
   assign w_start   = Enable_i & ~Mac_busy_i & (Src_count_i >= LP_PAY_LEN);

   // Header index of the byte to load on the next strobe: 0 when leaving PRE
   assign w_hdr_idx = (r_state == ST_HDR) ? w_cnt_inc[4:0] : 5'd0;

   // A payload byte is fetched on the strobe that retires the last header
   // byte and on every payload strobe except the one retiring the final byte
   assign w_pay_load = Data_strobe_i &
                       (((r_state == ST_HDR) && (r_cnt == LP_HDR_LAST)) ||
                        ((r_state == ST_PAY) && (r_cnt != LP_PAY_LAST)));

   // An empty FIFO substitutes a zero byte and is never popped
   assign w_pay_byte = Src_empty_i ? 8'h00 : Src_data_i;
   assign Src_rd_o   = w_pay_load & ~Src_empty_i;

   mac_hdr_sel u_hdr_sel (
      .i_idx       (w_hdr_idx),
      .i_dst_mac   (r_dst_mac),
      .i_src_mac   (r_src_mac),
      .i_ethertype (ETHERTYPE),
      .i_seq_cnt   (r_frame_cnt),
      .i_seq_len   (LP_SEQ_LEN),
      .o_byte      (w_hdr_byte)
   );

   // Frame sequencer: trigger handshake, byte streaming and frame accounting
   always_ff @(posedge clk or posedge Reset_i) begin
      if (Reset_i) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 14'd0;
         r_tmo       <= 16'd0;
         r_dst_mac   <= 48'd0;
         r_src_mac   <= 48'd0;
         r_data      <= PREAMBLE_BYTE;
         r_trig      <= 1'b0;
         r_last      <= 1'b0;
         r_frame_cnt <= 16'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state   <= ST_TRIG;
                  r_dst_mac <= Dst_mac_i;
                  r_src_mac <= Src_mac_i;
                  r_data    <= PREAMBLE_BYTE;
                  r_cnt     <= 14'd0;
                  r_tmo     <= 16'd0;
                  r_trig    <= 1'b1;
                  r_last    <= 1'b0;
               end
            end
            ST_TRIG: begin
               if (Mac_busy_i) begin
                  r_trig  <= 1'b0;
                  r_state <= ST_PRE;
               end else if (r_trig) begin
                  // Drop the request after the timeout so a fresh rising edge follows
                  if (r_tmo == LP_TMO_LAST) begin
                     r_trig <= 1'b0;
                     r_tmo  <= 16'd0;
                  end else begin
                     r_tmo <= r_tmo + 16'd1;
                  end
               end else begin
                  r_trig <= 1'b1;
               end
            end
            ST_PRE: begin
               if (Data_strobe_i) begin
                  if (r_cnt == LP_PRE_LAST) begin
                     r_state <= ST_HDR;
                     r_cnt   <= 14'd0;
                     r_data  <= w_hdr_byte;
                  end else begin
                     r_cnt  <= w_cnt_inc;
                     r_data <= (w_cnt_inc == LP_PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
                  end
               end
            end
            ST_HDR: begin
               if (Data_strobe_i) begin
                  if (r_cnt == LP_HDR_LAST) begin
                     r_state <= ST_PAY;
                     r_cnt   <= 14'd0;
                     r_data  <= w_pay_byte;
                  end else begin
                     r_cnt  <= w_cnt_inc;
                     r_data <= w_hdr_byte;
                  end
               end
            end
            ST_PAY: begin
               if (Data_strobe_i) begin
                  if (r_cnt == LP_PAY_LAST) begin
                     r_last      <= 1'b0;
                     r_state     <= ST_DONE;
                     r_frame_cnt <= r_frame_cnt + 16'd1;
                  end else begin
                     r_cnt  <= w_cnt_inc;
                     r_data <= w_pay_byte;
                     r_last <= (w_cnt_inc == LP_PAY_LAST);
                  end
               end
            end
            ST_DONE: begin
               if (!Mac_busy_i) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Sticky record of any payload byte requested while the FIFO was empty
   always_ff @(posedge clk or posedge Reset_i) begin
      if (Reset_i) begin
         r_underflow <= 1'b0;
      end else if (w_pay_load & Src_empty_i) begin
         r_underflow <= 1'b1;
      end
   end

   assign Trig_o      = r_trig;
   assign Data_o      = r_data;
   assign Last_byte_o = r_last;
   assign Frame_cnt_o = r_frame_cnt;
   assign Underflow_o = r_underflow;

endmodule
